// File: rtl/gpmc_wb_pkg.sv
// Shared types and constants for the GPMC-to-Wishbone bridge.
package gpmc_wb_pkg;

    localparam int GPMC_DW = 16;
    localparam int GPMC_AW = 10;

    // Data returned to the GPMC when a read is abandoned by the ack timeout.
    localparam logic [GPMC_DW-1:0] TIMEOUT_RDATA = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // One GPMC access as captured from the pins: word address, data, byte selects.
    typedef struct packed {
        logic [GPMC_AW-1:0] a;
        logic [GPMC_DW-1:0] d;
        logic [1:0]         sel;
    } wr_req_t;

    // Byte enables are active low on the pins, Wishbone selects are active high.
    function automatic wr_req_t capture_req(input logic [GPMC_AW-1:0] a,
                                            input logic [GPMC_DW-1:0] d,
                                            input logic [1:0]         nbe);
        wr_req_t r;
        r.a   = a;
        r.d   = d;
        r.sel = ~nbe;
        return r;
    endfunction

endpackage

// File: rtl/gpmc_async_wb_if.sv
// Wishbone master port of the GPMC bridge, plus the sticky dropped-write debug flag.
interface gpmc_async_wb_if #(
    parameter int AWIDTH = 11
);
    import gpmc_wb_pkg::*;

    logic [AWIDTH-1:0]  wb_adr_o;
    logic [GPMC_DW-1:0] wb_dat_o;
    logic [1:0]         wb_sel_o;
    logic               wb_we_o;
    logic               wb_cyc_o;
    logic               wb_stb_o;
    logic [GPMC_DW-1:0] wb_dat_i;
    logic               wb_ack_i;
    logic               drop_sticky;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, drop_sticky,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, drop_sticky,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/gpmc_sync_edge.sv
// Two-flop synchronizer for an asynchronous active-low strobe, with a third
// flop providing single-cycle rise/fall pulses. All flops reset to 1 (inactive).
module gpmc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    // [0] metastability flop, [1] synchronized level, [2] previous level
    logic [2:0] sh_r;

    // Shift the pin through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r <= 3'b111;
        end else begin
            sh_r <= {sh_r[1:0], async_in};
        end
    end

    assign level = sh_r[1];
    assign rise  = sh_r[1] & ~sh_r[2];
    assign fall  = ~sh_r[1] & sh_r[2];

endmodule

// File: rtl/gpmc_async_wb.sv
// GPMC async chip-select 6 to 16-bit Wishbone master bridge.
// Each GPMC write becomes one Wishbone write (one more may queue while busy),
// each GPMC read becomes one Wishbone read held on the pads under EM_WAIT0.
// Optional macro GPMC_WB_TIMEOUT_EN: abandon Wishbone cycles not acked within TIMEOUT clocks.
module gpmc_async_wb
    import gpmc_wb_pkg::*;
#(
    parameter int AWIDTH  = 11,
    parameter int DWIDTH  = GPMC_DW,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               EM_NCS6,
    input  logic               EM_NWE,
    input  logic               EM_NOE,
    input  logic [GPMC_AW-1:0] EM_A,
    input  logic [1:0]         EM_NBE,
    input  logic [DWIDTH-1:0]  em_d_in,
    output logic [DWIDTH-1:0]  em_d_out,
    output logic               em_d_oe,
    output logic               EM_WAIT0,
    output logic               timeout_o,
    gpmc_async_wb_if.master    wb
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    logic ncs_s, noe_s, nwe_rise_s, noe_fall_s;
    logic unused_ncs_rise_s, unused_ncs_fall_s;
    logic unused_nwe_level_s, unused_nwe_fall_s, unused_noe_rise_s;

    gpmc_sync_edge u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .async_in(EM_NCS6),
        .level(ncs_s), .rise(unused_ncs_rise_s), .fall(unused_ncs_fall_s)
    );
    gpmc_sync_edge u_sync_nwe (
        .clk(clk), .rst_n(rst_n), .async_in(EM_NWE),
        .level(unused_nwe_level_s), .rise(nwe_rise_s), .fall(unused_nwe_fall_s)
    );
    gpmc_sync_edge u_sync_noe (
        .clk(clk), .rst_n(rst_n), .async_in(EM_NOE),
        .level(noe_s), .rise(unused_noe_rise_s), .fall(noe_fall_s)
    );

    state_t              state_r;
    wr_req_t             cur_r, pend_r;
    logic                pend_valid_r, we_r, cyc_r, oe_r, wait_r, cs_lost_r, drop_r;
    logic [DWIDTH-1:0]   em_d_out_r;
    wr_req_t             new_req_s;
    logic                wr_ev_s, rd_ev_s, abort_s, done_s, to_hit_s;

    assign new_req_s = capture_req(EM_A, em_d_in, EM_NBE);
    assign wr_ev_s   = nwe_rise_s & ~ncs_s;
    assign rd_ev_s   = noe_fall_s & ~ncs_s;
    // Losing CS or NOE at any point of a read means nobody will sample the data.
    assign abort_s   = cs_lost_r | ncs_s | noe_s;
    assign done_s    = wb.wb_ack_i | to_hit_s;

`ifdef GPMC_WB_TIMEOUT_EN
    logic [7:0] cnt_r;
    logic       timeout_r;

    assign to_hit_s = ((state_r == ST_WR) || (state_r == ST_RD)) &&
                      (cnt_r == TO_LIMIT) && !wb.wb_ack_i;

    // Ack-wait counter: zero on entry to every Wishbone cycle, counts while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if ((state_r != ST_WR) && (state_r != ST_RD)) begin
            cnt_r <= 8'd0;
        end else if (done_s) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    // One-cycle pulse for each abandoned Wishbone cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= to_hit_s;
        end
    end

    assign timeout_o = timeout_r;
`else
    logic unused_to_s;

    assign to_hit_s    = 1'b0;
    assign timeout_o   = 1'b0;
    assign unused_to_s = ^TO_LIMIT;
`endif

    // Bridge FSM: one Wishbone cycle per GPMC strobe event; owns every bus and pad output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cur_r        <= '0;
            pend_r       <= '0;
            pend_valid_r <= 1'b0;
            we_r         <= 1'b0;
            cyc_r        <= 1'b0;
            oe_r         <= 1'b0;
            wait_r       <= 1'b0;
            cs_lost_r    <= 1'b0;
            drop_r       <= 1'b0;
            em_d_out_r   <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wr_ev_s) begin
                        cur_r   <= new_req_s;
                        we_r    <= 1'b1;
                        cyc_r   <= 1'b1;
                        state_r <= ST_WR;
                    end else if (rd_ev_s) begin
                        cur_r     <= new_req_s;
                        we_r      <= 1'b0;
                        cyc_r     <= 1'b1;
                        wait_r    <= 1'b1;
                        cs_lost_r <= 1'b0;
                        state_r   <= ST_RD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (done_s) begin
                        // Pending write goes out back-to-back, keeping cyc/stb high.
                        if (pend_valid_r) begin
                            cur_r <= pend_r;
                            if (wr_ev_s) begin
                                pend_r <= new_req_s;
                            end else begin
                                pend_valid_r <= 1'b0;
                            end
                        end else if (wr_ev_s) begin
                            cur_r <= new_req_s;
                        end else begin
                            cyc_r   <= 1'b0;
                            we_r    <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end else if (wr_ev_s) begin
                        if (pend_valid_r) begin
                            drop_r <= 1'b1;
                        end else begin
                            pend_r       <= new_req_s;
                            pend_valid_r <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    cs_lost_r <= abort_s;
                    if (done_s) begin
                        cyc_r  <= 1'b0;
                        wait_r <= 1'b0;
                        if (abort_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            em_d_out_r <= wb.wb_ack_i ? wb.wb_dat_i : TIMEOUT_RDATA;
                            oe_r       <= 1'b1;
                            state_r    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (ncs_s || noe_s) begin
                        oe_r    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    cyc_r        <= 1'b0;
                    we_r         <= 1'b0;
                    oe_r         <= 1'b0;
                    wait_r       <= 1'b0;
                    pend_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb.wb_adr_o    = AWIDTH'({cur_r.a, 1'b0});
    assign wb.wb_dat_o    = cur_r.d;
    assign wb.wb_sel_o    = cur_r.sel;
    assign wb.wb_we_o     = we_r;
    assign wb.wb_cyc_o    = cyc_r;
    assign wb.wb_stb_o    = cyc_r;
    assign wb.drop_sticky = drop_r;
    assign em_d_out       = em_d_out_r;
    assign em_d_oe        = oe_r;
    assign EM_WAIT0       = wait_r;

endmodule

// File: tb/tb_gpmc_async_wb.sv
// Self-checking bench for gpmc_async_wb: directed GPMC pin sequences, a
// Wishbone slave with programmable ack delay, and a transaction-level model
// (queue of expected Wishbone transfers) checked on every acked cycle.
module tb_gpmc_async_wb;

    logic        clk;
    logic        rst_n;
    logic        ncs, nwe, noe;
    logic [9:0]  em_a;
    logic [1:0]  em_nbe;
    logic [15:0] d_in;
    logic [15:0] em_d_out;
    logic        em_d_oe, em_wait0, timeout_o;

    gpmc_async_wb_if #(.AWIDTH(11)) bus ();

    gpmc_async_wb #(.AWIDTH(11), .DWIDTH(16), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .EM_NCS6(ncs), .EM_NWE(nwe), .EM_NOE(noe),
        .EM_A(em_a), .EM_NBE(em_nbe), .em_d_in(d_in),
        .em_d_out(em_d_out), .em_d_oe(em_d_oe), .EM_WAIT0(em_wait0),
        .timeout_o(timeout_o), .wb(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic        we;
    } xfer_t;

    xfer_t       exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          stb_cycles = 0;
    int          stb_rises = 0;
    logic        prev_stb = 1'b0;
    logic        oe_allowed = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic [15:0] exp_rdata = 16'h0000;
    logic [10:0] last_adr = 11'h000;
    logic [15:0] last_dat = 16'h0000;
    logic [1:0]  last_sel = 2'b00;
    logic        last_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic xfer_t mk(input logic [9:0] a, input logic [15:0] d,
                                 input logic [1:0] nbe, input logic we);
        xfer_t x;
        x.adr = {a, 1'b0};
        x.dat = d;
        x.sel = ~nbe;
        x.we  = we;
        return x;
    endfunction

    // Called on each acked Wishbone cycle: the transfer must be the oldest one the model expects.
    task automatic check_xfer();
        xfer_t e;
        last_adr = bus.wb_adr_o;
        last_dat = bus.wb_dat_o;
        last_sel = bus.wb_sel_o;
        last_we  = bus.wb_we_o;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_xfer: got adr %0h we %0b, expected no transfer",
                     bus.wb_adr_o, bus.wb_we_o);
        end else begin
            e = exp_q.pop_front();
            chk("xfer_adr", 32'(bus.wb_adr_o), 32'(e.adr));
            chk("xfer_we",  32'(bus.wb_we_o),  32'(e.we));
            chk("xfer_sel", 32'(bus.wb_sel_o), 32'(e.sel));
            if (e.we) chk("xfer_dat", 32'(bus.wb_dat_o), 32'(e.dat));
        end
    endtask

    // Wishbone slave and per-cycle compare, both on the falling edge.
    initial begin
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst_n && bus.wb_cyc_o && bus.wb_stb_o) begin
                stb_cycles++;
                if (!prev_stb) stb_rises++;
                prev_stb = 1'b1;
                if (wait_cnt >= ack_delay) begin
                    bus.wb_ack_i = 1'b1;
                    bus.wb_dat_i = rd_data;
                    wait_cnt     = 0;
                    check_xfer();
                end else begin
                    bus.wb_ack_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.wb_ack_i = 1'b0;
                wait_cnt     = 0;
                prev_stb     = 1'b0;
            end
            if (em_d_oe) begin
                chk("oe_allowed", 32'(oe_allowed), 32'd1);
                chk("oe_data", 32'(em_d_out), 32'(exp_rdata));
            end
`ifndef GPMC_WB_TIMEOUT_EN
            if (timeout_o) chk("timeout_tied_low", 32'(timeout_o), 32'd0);
`endif
        end
    end

    task automatic wait_q(input string name, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk({name, "_done"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] nbe);
        exp_q.push_back(mk(a, d, nbe, 1'b1));
        @(posedge clk); #2;
        ncs = 1'b0; em_a = a; d_in = d; em_nbe = nbe; nwe = 1'b0;
        repeat (2) @(posedge clk);
        #2 nwe = 1'b1;
        repeat (4) @(posedge clk);
        #2 ncs = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // n writes inside one chip-select window, write strobes rising 6 clk apart.
    task automatic wr_burst(input int n, input logic [9:0] base);
        @(posedge clk); #2 ncs = 1'b0;
        for (int k = 0; k < n; k++) begin
            em_a = base + 10'(k); d_in = 16'hC000 + 16'(k); em_nbe = 2'b00; nwe = 1'b0;
            repeat (2) @(posedge clk);
            #2 nwe = 1'b1;
            repeat (4) @(posedge clk);
            #2;
        end
        ncs = 1'b1;
    endtask

    task automatic rd(input logic [9:0] a, input logic [15:0] data, input int delay);
        int lat;
        exp_q.push_back(mk(a, 16'h0000, 2'b00, 1'b0));
        rd_data = data; exp_rdata = data; ack_delay = delay; oe_allowed = 1'b1;
        @(posedge clk); #2;
        ncs = 1'b0; em_a = a; em_nbe = 2'b00; noe = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (em_wait0) lat = i;
        end
        chk("rd_wait_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 40 && !em_d_oe; i++) begin
            @(posedge clk); #1;
        end
        chk("rd_oe", 32'(em_d_oe), 32'd1);
        chk("rd_data", 32'(em_d_out), 32'(data));
        chk("rd_wait_low", 32'(em_wait0), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("rd_hold_oe", 32'(em_d_oe), 32'd1);
        #1 noe = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (!em_d_oe) lat = i;
        end
        chk("rd_oe_release", 32'(lat), 32'd3);
        oe_allowed = 1'b0;
        #1 ncs = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; ncs = 1'b1; nwe = 1'b1; noe = 1'b1;
        em_a = 10'h000; em_nbe = 2'b11; d_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
        chk("rst_wait", 32'(em_wait0), 32'd0);
        chk("rst_oe", 32'(em_d_oe), 32'd0);
        chk("rst_dout", 32'(em_d_out), 32'h0000);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single write, zero-wait slave: exactly one stb cycle.
        ack_delay = 0; stb_cycles = 0;
        wr(10'h005, 16'h1234, 2'b00);
        wait_q("wr1", 20);
        chk("wr1_adr", 32'(last_adr), 32'h00A);
        chk("wr1_dat", 32'(last_dat), 32'h1234);
        chk("wr1_sel", 32'(last_sel), 32'h3);
        chk("wr1_we", 32'(last_we), 32'd1);
        chk("wr1_stb_cycles", 32'(stb_cycles), 32'd1);

        // Read with ack after 4 clk.
        rd(10'h010, 16'hBEEF, 4);
        wait_q("rd1", 10);

        // Two writes 6 clk apart, ack delayed 10: 11 + 11 contiguous stb cycles.
        ack_delay = 10; stb_cycles = 0; stb_rises = 0;
        exp_q.push_back(mk(10'h020, 16'hC000, 2'b00, 1'b1));
        exp_q.push_back(mk(10'h021, 16'hC001, 2'b00, 1'b1));
        wr_burst(2, 10'h020);
        wait_q("b2b", 80);
        chk("b2b_stb_cycles", 32'(stb_cycles), 32'd22);
        chk("b2b_stb_rises", 32'(stb_rises), 32'd1);
        chk("b2b_no_drop", 32'(bus.drop_sticky), 32'd0);

        // Three writes while the first is stalled: the third one is dropped.
        ack_delay = 30;
        exp_q.push_back(mk(10'h040, 16'hC000, 2'b00, 1'b1));
        exp_q.push_back(mk(10'h041, 16'hC001, 2'b00, 1'b1));
        wr_burst(3, 10'h040);
        wait_q("drop", 200);
        chk("drop_sticky", 32'(bus.drop_sticky), 32'd1);

        // Chip select lost during the Wishbone read: read completes, pad never driven.
        ack_delay = 6; oe_allowed = 1'b0; rd_data = 16'h5555;
        exp_q.push_back(mk(10'h077, 16'h0000, 2'b00, 1'b0));
        @(posedge clk); #2;
        ncs = 1'b0; em_a = 10'h077; em_nbe = 2'b00; noe = 1'b0;
        for (int i = 0; i < 10 && !em_wait0; i++) begin
            @(posedge clk); #1;
        end
        chk("abort_wait_hi", 32'(em_wait0), 32'd1);
        #1 ncs = 1'b1; noe = 1'b1;
        wait_q("abort", 30);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("abort_wait_lo", 32'(em_wait0), 32'd0);
        chk("abort_oe", 32'(em_d_oe), 32'd0);

        // Reset while a write is stalled in WR, then a normal write.
        ack_delay = 1000;
        wr(10'h055, 16'h7777, 2'b00);
        #1 chk("rstwr_cyc_pre", 32'(bus.wb_cyc_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstwr_cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("rstwr_stb", 32'(bus.wb_stb_o), 32'd0);
        chk("rstwr_wait", 32'(em_wait0), 32'd0);
        chk("rstwr_oe", 32'(em_d_oe), 32'd0);
        chk("rstwr_drop_clr", 32'(bus.drop_sticky), 32'd0);
        exp_q.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        ack_delay = 0;
        wr(10'h3FF, 16'hA5A5, 2'b10);
        wait_q("postrst", 20);
        chk("postrst_adr", 32'(last_adr), 32'h7FE);
        chk("postrst_sel", 32'(last_sel), 32'h1);
        chk("postrst_dat", 32'(last_dat), 32'hA5A5);

`ifdef GPMC_WB_TIMEOUT_EN
        // Unacked read: counter is 0 on RD entry and hits 255 on the 256th stb cycle.
        ack_delay = 1000; exp_rdata = 16'hDEAD; oe_allowed = 1'b1;
        @(posedge clk); #2;
        ncs = 1'b0; em_a = 10'h011; em_nbe = 2'b00; noe = 1'b0;
        for (int i = 0; i < 10 && !em_wait0; i++) begin
            @(posedge clk); #1;
        end
        lat = 0;
        for (int i = 1; i <= 400 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (timeout_o) lat = i;
        end
        chk("to_latency", 32'(lat), 32'd256);
        chk("to_oe", 32'(em_d_oe), 32'd1);
        chk("to_dead", 32'(em_d_out), 32'hDEAD);
        chk("to_wait_lo", 32'(em_wait0), 32'd0);
        @(posedge clk); #1 chk("to_pulse_one", 32'(timeout_o), 32'd0);
        noe = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("to_release", 32'(em_d_oe), 32'd0);
        oe_allowed = 1'b0; ncs = 1'b1;
`else
        lat = 0;
`endif

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
